// File: rtl/data_memory_lsu.sv
// RV32 byte-addressed data memory with load/store front end and a READ_LAT-deep response pipe.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned.
module data_memory_lsu #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Req,
  output logic              o_Ready,
  input  logic              i_WE,
  input  logic [2:0]        iv_Funct3,
  input  logic [ADDR_W-1:0] iv_Address,
  input  logic [31:0]       iv_Data,
  output logic [31:0]       ov_Data,
  output logic              o_Valid,
  output logic              o_Fault
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef struct packed {
    logic        vld;
    logic        flt;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
  } slot_t;

  logic [31:0]       mem_r [DEPTH];
  logic              ready_r;
  logic              valid_r;
  logic              fault_r;
  logic [31:0]       data_r;
  logic              accept_s;
  logic              legal_s;
  logic              fault_s;
  logic              wr_en_s;
  logic [1:0]        off_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [ADDR_W-3:0] idx_s;
  slot_t             head_s;
  slot_t             tail_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h000000, b};
      3'b101:  load_extract = {16'h0000, h};
      default: load_extract = word;
    endcase
  endfunction

  // Request decode: legality, lane offset, byte enables and the pipe head entry.
  always_comb begin
    idx_s    = iv_Address[ADDR_W-1:2];
    accept_s = i_Req & ready_r;
    off_s    = iv_Address[1:0];
    be_s     = 4'b0000;
    wdata_s  = iv_Data;
    case (iv_Funct3)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = ~i_WE;
      default:                legal_s = 1'b0;
    endcase
    case (iv_Funct3[1:0])
      2'b00: begin
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{iv_Data[7:0]}};
      end
      2'b01: begin
        off_s[0] = 1'b0;
        be_s     = off_s[1] ? 4'b1100 : 4'b0011;
        wdata_s  = {2{iv_Data[15:0]}};
      end
      2'b10: begin
        off_s = 2'b00;
        be_s  = 4'b1111;
      end
      default: be_s = 4'b0000;
    endcase
    // A forced-aligned offset that differs from the request offset means the access was misaligned.
`ifdef DMEM_MISALIGN_TRAP_EN
    fault_s = ~legal_s | (off_s != iv_Address[1:0]);
`else
    fault_s = ~legal_s;
`endif
    wr_en_s     = accept_s & i_WE & ~fault_s;
    head_s.vld  = accept_s & ~i_WE & ~fault_s;
    head_s.flt  = accept_s & fault_s;
    head_s.f3   = iv_Funct3;
    head_s.off  = off_s;
    head_s.word = mem_r[idx_s];
  end

  // Byte-lane writes into the array; contents are deliberately not reset.
  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

  generate
    if (READ_LAT > 1) begin : g_pipe
      slot_t pipe_r [READ_LAT-1];
      // Latency pipe carrying the raw word plus extraction metadata.
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          for (int i = 0; i < READ_LAT - 1; i++) begin
            pipe_r[i] <= '0;
          end
        end else begin
          pipe_r[0] <= head_s;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end
      assign tail_s = pipe_r[READ_LAT-2];
    end else begin : g_direct
      assign tail_s = head_s;
    end
  endgenerate

  // Response registers; load data is held until the next load response.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      data_r  <= 32'h0000_0000;
    end else begin
      ready_r <= 1'b1;
      valid_r <= tail_s.vld;
      fault_r <= tail_s.flt;
      if (tail_s.vld) begin
        data_r <= load_extract(tail_s.f3, tail_s.off, tail_s.word);
      end
    end
  end

  assign o_Ready = ready_r;
  assign o_Valid = valid_r;
  assign o_Fault = fault_r;
  assign ov_Data = data_r;

endmodule
